// File: rtl/imm_gen_pipe.sv
// Registered RV32I/RV64I immediate generator with PC-relative target.
// Decoded results are queued in a small skid FIFO with valid/ready on both sides.
module imm_gen_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal
);

    localparam bit          Is64    = (XLEN == 64);
    localparam int unsigned PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned Entries = 1 << PtrW;
    localparam int unsigned CntW    = $clog2(DEPTH + 1);

    localparam logic [CntW-1:0] DepthC  = CntW'(DEPTH);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

    localparam logic [2:0] FmtNone = 3'd0;
    localparam logic [2:0] FmtI    = 3'd1;
    localparam logic [2:0] FmtS    = 3'd2;
    localparam logic [2:0] FmtB    = 3'd3;
    localparam logic [2:0] FmtU    = 3'd4;
    localparam logic [2:0] FmtJ    = 3'd5;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpSystem = 7'b1110011;
    localparam logic [6:0] OpImm32  = 7'b0011011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpReg32  = 7'b0111011;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [2:0]      w_fmt;
    logic [31:0]     w_imm32;
    logic            w_illegal;
    logic            w_pc_rel;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_target;

    assign w_opcode = in_inst[6:0];
    assign w_funct3 = in_inst[14:12];

    always_comb begin
        w_fmt     = FmtNone;
        w_imm32   = '0;
        w_illegal = 1'b0;
        w_pc_rel  = 1'b0;
        case (w_opcode)
            OpLoad, OpImm, OpJalr, OpSystem: begin
                w_fmt   = FmtI;
                w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            OpImm32: begin
                if (Is64) begin
                    w_fmt   = FmtI;
                    w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
                end else begin
                    w_illegal = 1'b1;
                end
            end
            OpStore: begin
                w_fmt   = FmtS;
                w_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            OpBranch: begin
                w_fmt    = FmtB;
                w_pc_rel = 1'b1;
                w_imm32  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                            in_inst[11:8], 1'b0};
            end
            OpLui: begin
                w_fmt   = FmtU;
                w_imm32 = {in_inst[31:12], 12'b0};
            end
            OpAuipc: begin
                w_fmt    = FmtU;
                w_pc_rel = 1'b1;
                w_imm32  = {in_inst[31:12], 12'b0};
            end
            OpJal: begin
                w_fmt    = FmtJ;
                w_pc_rel = 1'b1;
                w_imm32  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                            in_inst[30:21], 1'b0};
            end
            OpReg: ;
            OpReg32: w_illegal = !Is64;
            default: w_illegal = 1'b1;
        endcase
        // Shift-immediates carry only the shamt; funct7/funct6 bits are dropped.
        if (w_fmt == FmtI && (w_opcode == OpImm || w_opcode == OpImm32) &&
            (w_funct3 == 3'b001 || w_funct3 == 3'b101)) begin
            w_imm32 = (Is64 && w_opcode == OpImm) ? {26'b0, in_inst[25:20]}
                                                  : {27'b0, in_inst[24:20]};
        end
    end

    assign w_imm    = XLEN'($signed(w_imm32));
    assign w_target = w_pc_rel ? in_pc + w_imm : '0;

    logic [CntW-1:0] r_count;
    logic [CntW-1:0] w_count_d;
    logic [PtrW-1:0] r_wptr;
    logic [PtrW-1:0] r_rptr;
    logic            r_in_ready;
    logic [XLEN-1:0] r_imm     [Entries];
    logic [2:0]      r_fmt     [Entries];
    logic [XLEN-1:0] r_target  [Entries];
    logic            r_illegal [Entries];

    logic w_accept;
    logic w_deliver;
    logic w_push;

    assign w_accept  = in_valid & r_in_ready;
    assign w_deliver = out_valid & out_ready;
    assign w_push    = w_accept & ~flush;

    always_comb begin
        w_count_d = r_count;
        if (flush) begin
            w_count_d = '0;
        end else if (w_accept && !w_deliver) begin
            w_count_d = r_count + CntW'(1);
        end else if (!w_accept && w_deliver) begin
            w_count_d = r_count - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_in_ready <= 1'b0;
            for (int i = 0; i < Entries; i++) begin
                r_imm[i]     <= '0;
                r_fmt[i]     <= '0;
                r_target[i]  <= '0;
                r_illegal[i] <= 1'b0;
            end
        end else begin
            r_count    <= w_count_d;
            // Registered copy of (count < DEPTH) keeps out_ready off the in_ready path.
            r_in_ready <= (w_count_d < DepthC);
            if (flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= (r_wptr == LastPtr) ? '0 : r_wptr + PtrW'(1);
                end
                if (w_deliver) begin
                    r_rptr <= (r_rptr == LastPtr) ? '0 : r_rptr + PtrW'(1);
                end
            end
            if (w_push) begin
                r_imm[r_wptr]     <= w_imm;
                r_fmt[r_wptr]     <= w_fmt;
                r_target[r_wptr]  <= w_target;
                r_illegal[r_wptr] <= w_illegal;
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = (r_count != '0);
    assign out_imm     = out_valid ? r_imm[r_rptr]     : '0;
    assign out_fmt     = out_valid ? r_fmt[r_rptr]     : '0;
    assign out_target  = out_valid ? r_target[r_rptr]  : '0;
    assign out_illegal = out_valid ? r_illegal[r_rptr] : 1'b0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three configurations (32/2, 64/2, 32/1) share one stimulus
// stream and are checked every cycle against an arithmetic queue model.
module tb_imm_gen_pipe;

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic [63:0] tgt;
        logic        ill;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc;

    logic        rdy0, ov0, ill0;
    logic [31:0] imm0, tgt0;
    logic [2:0]  fmt0;
    logic        rdy1, ov1, ill1;
    logic [63:0] imm1, tgt1;
    logic [2:0]  fmt1;
    logic        rdy2, ov2, ill2;
    logic [31:0] imm2, tgt2;
    logic [2:0]  fmt2;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .DEPTH(2)) u_d0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
        .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_valid(ov0), .out_ready(out_ready),
        .out_imm(imm0), .out_fmt(fmt0), .out_target(tgt0), .out_illegal(ill0)
    );

    imm_gen_pipe #(.XLEN(64), .DEPTH(2)) u_d1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(ov1), .out_ready(out_ready),
        .out_imm(imm1), .out_fmt(fmt1), .out_target(tgt1), .out_illegal(ill1)
    );

    imm_gen_pipe #(.XLEN(32), .DEPTH(1)) u_d2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy2),
        .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_valid(ov2), .out_ready(out_ready),
        .out_imm(imm2), .out_fmt(fmt2), .out_target(tgt2), .out_illegal(ill2)
    );

    // Model state: a small circular queue per configuration.
    ent_t mmem [3][4];
    int   mhead [3];
    int   mcnt  [3];
    bit   mrdy  [3];
    int   mdepth[3] = '{2, 2, 1};
    int   mxl   [3] = '{32, 64, 32};

    function automatic longint w(input bit b, input longint wt);
        return b ? wt : 64'sd0;
    endfunction

    function automatic logic [63:0] mask(input int xl, input logic [63:0] v);
        return (xl == 32) ? {32'b0, v[31:0]} : v;
    endfunction

    // Immediate value as a weighted sum of instruction fields (two's-complement top bit).
    function automatic ent_t predict(input logic [31:0] inst, input logic [63:0] pc,
                                     input int xl);
        ent_t       e;
        longint     v;
        bit         rel;
        logic [6:0] op;
        logic [2:0] f3;
        e   = '0;
        v   = 0;
        rel = 1'b0;
        op  = inst[6:0];
        f3  = inst[14:12];
        case (op)
            7'h03, 7'h13, 7'h67, 7'h73: begin
                e.fmt = 3'd1;
                v = -w(inst[31], 2048) + longint'(inst[30:20]);
            end
            7'h1B: begin
                if (xl == 64) begin
                    e.fmt = 3'd1;
                    v = -w(inst[31], 2048) + longint'(inst[30:20]);
                end else begin
                    e.ill = 1'b1;
                end
            end
            7'h23: begin
                e.fmt = 3'd2;
                v = -w(inst[31], 2048) + longint'(inst[30:25]) * 32 + longint'(inst[11:7]);
            end
            7'h63: begin
                e.fmt = 3'd3;
                rel = 1'b1;
                v = -w(inst[31], 4096) + w(inst[7], 2048) + longint'(inst[30:25]) * 32
                    + longint'(inst[11:8]) * 2;
            end
            7'h37, 7'h17: begin
                e.fmt = 3'd4;
                rel = (op == 7'h17);
                v = -w(inst[31], 64'h8000_0000) + longint'(inst[30:12]) * 4096;
            end
            7'h6F: begin
                e.fmt = 3'd5;
                rel = 1'b1;
                v = -w(inst[31], 64'h10_0000) + longint'(inst[19:12]) * 4096
                    + w(inst[20], 2048) + longint'(inst[30:21]) * 2;
            end
            7'h33: ;
            7'h3B: e.ill = (xl != 64);
            default: e.ill = 1'b1;
        endcase
        if (e.fmt == 3'd1 && (op == 7'h13 || op == 7'h1B) && (f3 == 3'd1 || f3 == 3'd5)) begin
            v = (op == 7'h13 && xl == 64) ? longint'(inst[25:20]) : longint'(inst[24:20]);
        end
        e.imm = mask(xl, v);
        e.tgt = rel ? mask(xl, mask(xl, pc) + v) : 64'd0;
        return e;
    endfunction

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
        end
    endtask

    task automatic model_step();
        bit acc, del;
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                mcnt[k]  = 0;
                mhead[k] = 0;
                mrdy[k]  = 1'b0;
            end else begin
                acc = in_valid && mrdy[k];
                del = (mcnt[k] != 0) && out_ready;
                if (flush) begin
                    mcnt[k]  = 0;
                    mhead[k] = 0;
                end else begin
                    if (del) begin
                        mhead[k] = (mhead[k] + 1) % 4;
                        mcnt[k]--;
                    end
                    if (acc) begin
                        mmem[k][(mhead[k] + mcnt[k]) % 4] = predict(in_inst, in_pc, mxl[k]);
                        mcnt[k]++;
                    end
                end
                mrdy[k] = (mcnt[k] < mdepth[k]);
            end
        end
    endtask

    task automatic check_all();
        ent_t        e;
        logic        d_rdy, d_ov, d_ill;
        logic [63:0] d_imm, d_tgt;
        logic [2:0]  d_fmt;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: begin
                    d_rdy = rdy0; d_ov = ov0; d_ill = ill0; d_fmt = fmt0;
                    d_imm = {32'b0, imm0}; d_tgt = {32'b0, tgt0};
                end
                1: begin
                    d_rdy = rdy1; d_ov = ov1; d_ill = ill1; d_fmt = fmt1;
                    d_imm = imm1; d_tgt = tgt1;
                end
                default: begin
                    d_rdy = rdy2; d_ov = ov2; d_ill = ill2; d_fmt = fmt2;
                    d_imm = {32'b0, imm2}; d_tgt = {32'b0, tgt2};
                end
            endcase
            e = (mcnt[k] != 0) ? mmem[k][mhead[k]] : '0;
            cmp($sformatf("d%0d_in_ready", k), d_rdy, mrdy[k]);
            cmp($sformatf("d%0d_out_valid", k), d_ov, mcnt[k] != 0);
            cmp($sformatf("d%0d_out_imm", k), d_imm, e.imm);
            cmp($sformatf("d%0d_out_fmt", k), d_fmt, e.fmt);
            cmp($sformatf("d%0d_out_target", k), d_tgt, e.tgt);
            cmp($sformatf("d%0d_out_illegal", k), d_ill, e.ill);
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, check at the negedge.
    task automatic cyc(input bit r, input bit f, input bit v, input bit o,
                       input logic [31:0] ins, input logic [63:0] pc);
        rst_n     = r;
        flush     = f;
        in_valid  = v;
        out_ready = o;
        in_inst   = ins;
        in_pc     = pc;
        model_step();
        @(negedge clk);
        check_all();
    endtask

    logic [31:0] vec_inst [10] = '{32'hFFF00093, 32'hFE000EE3, 32'h0080006F, 32'h01F09093,
                                   32'h4030D093, 32'h123452B7, 32'h800002B7, 32'h0000000B,
                                   32'h0010809B, 32'h002081B3};
    logic [63:0] vec_pc   [10] = '{64'h0, 64'h100, 64'hFFFF_FFFF_FFFF_FFFC, 64'h40, 64'h44,
                                   64'h48, 64'h8000_0000, 64'h50, 64'h54, 64'h58};
    logic [6:0]  ops      [14] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h1B, 7'h23, 7'h63, 7'h37,
                                   7'h17, 7'h6F, 7'h33, 7'h3B, 7'h0B, 7'h7F};

    initial begin
        ent_t        e;
        bit          r, f, v, o, hold, last_rdy;
        logic [31:0] ins, tmp;
        logic [63:0] pc;

        // Hand-computed values that pin the model itself.
        e = predict(32'hFFF00093, 64'h0, 32);
        cmp("m_addi_imm", e.imm, 64'hFFFF_FFFF);
        cmp("m_addi_fmt", e.fmt, 3'd1);
        e = predict(32'hFE000EE3, 64'h100, 32);
        cmp("m_beq_imm", e.imm, 64'hFFFF_FFFC);
        cmp("m_beq_tgt", e.tgt, 64'hFC);
        e = predict(32'h0080006F, 64'hFFFF_FFFC, 32);
        cmp("m_jal_imm", e.imm, 64'h8);
        cmp("m_jal_tgt", e.tgt, 64'h4);
        e = predict(32'h01F09093, 64'h0, 32);
        cmp("m_slli_imm", e.imm, 64'h1F);
        e = predict(32'h4030D093, 64'h0, 32);
        cmp("m_srai_imm", e.imm, 64'h3);
        e = predict(32'h123452B7, 64'h0, 32);
        cmp("m_lui_imm", e.imm, 64'h1234_5000);
        cmp("m_lui_fmt", e.fmt, 3'd4);
        e = predict(32'h800002B7, 64'h0, 64);
        cmp("m_lui64_imm", e.imm, 64'hFFFF_FFFF_8000_0000);
        e = predict(32'h0000000B, 64'h0, 32);
        cmp("m_bad_ill", e.ill, 1'b1);
        e = predict(32'h0010809B, 64'h0, 32);
        cmp("m_addiw32_ill", e.ill, 1'b1);
        e = predict(32'h002081B3, 64'h0, 32);
        cmp("m_add_ill", e.ill, 1'b0);

        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 64'h0);
        cmp("rst_in_ready", rdy0, 1'b0);
        cmp("rst_out_valid", ov0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 64'h0);
        cmp("rel_in_ready", rdy0, 1'b1);

        // Directed vectors streamed with the consumer always ready.
        cyc(1'b1, 1'b0, 1'b1, 1'b1, vec_inst[0], vec_pc[0]);
        cmp("t1_out_valid", ov0, 1'b1);
        cmp("t1_out_imm", imm0, 32'hFFFF_FFFF);
        cmp("t1_out_fmt", fmt0, 3'd1);
        for (int i = 1; i < 10; i++) cyc(1'b1, 1'b0, 1'b1, 1'b1, vec_inst[i], vec_pc[i]);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 64'h0);

        // Backpressure: A, B, C with consumer stalled, then drain.
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h00100093, 64'h200);
        cmp("bp_d0_ready_after_a", rdy0, 1'b1);
        cmp("bp_d2_ready_after_a", rdy2, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h00200113, 64'h204);
        cmp("bp_d0_ready_after_b", rdy0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h00300193, 64'h208);
        repeat (3) cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'h00300193, 64'h208);
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 64'h0);

        // Flush with a full buffer and a beat on the input.
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'hFE000EE3, 64'h300);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0080006F, 64'h304);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h123452B7, 64'h308);
        cmp("fl_out_valid", ov0, 1'b0);
        cmp("fl_in_ready", rdy0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 64'h0);

        // Reset with one entry buffered.
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'hFFF00093, 64'h400);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
        cmp("mr_out_valid", ov0, 1'b0);
        cmp("mr_out_imm", imm0, 32'h0);
        cmp("mr_in_ready", rdy0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 64'h0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'h0080006F, 64'h500);
        cmp("mr_new_target", tgt0, 32'h508);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 64'h0);

        // Randomized traffic; producer holds a beat until every configuration took it.
        v        = 1'b0;
        ins      = '0;
        pc       = '0;
        last_rdy = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            r    = ($urandom_range(0, 99) != 0);
            f    = ($urandom_range(0, 19) == 0);
            o    = ($urandom_range(0, 9) < 6);
            hold = v && !last_rdy && rst_n;
            if (!hold) begin
                v   = ($urandom_range(0, 9) < 7);
                tmp = $urandom();
                ins = {tmp[31:7], ops[$urandom_range(0, 13)]};
                pc  = {$urandom(), $urandom()};
            end
            last_rdy = mrdy[0] && mrdy[1] && mrdy[2];
            cyc(r, f, v, o, ins, pc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
